// File: rtl/event_encoder_8to3.sv
`default_nettype none
// ============================================================================
//  Module   : event_encoder_8to3
//  Purpose  : Captures eight event request lines into a pending vector and
//             hands them out one at a time as 3-bit indices over a
//             valid/ready handshake, in fixed priority order.
//  Revision : 1.0  initial release
// ============================================================================
module event_encoder_8to3 #(
    parameter int unsigned HIGH_FIRST = 1   // 1: index 7 wins, 0: index 0 wins
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [2:0] out_idx,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] pending,
    output logic       ovf,
    input  logic       ovf_clr
);

    // Two-state presenter: IDLE has nothing on the output, PRESENT holds one
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    logic [0:0] state_q,   state_d;
    logic [2:0] out_idx_q, out_idx_d;
    logic [7:0] pending_q, pending_d;
    logic       ovf_q,     ovf_d;

    logic       accept;     // handshake completes at this edge
    logic [7:0] idx_onehot; // one-hot of the presented index
    logic [7:0] acc_mask;   // pending bit retired by this edge's accept
    logic [7:0] cand;       // what remains eligible after the accept
    logic       ovf_set;    // a request collided with a still-pending bit

    // Priority encoder; the loop direction makes the last hit the winner
    function automatic logic [2:0] prio_sel(input logic [7:0] v);
        logic [2:0] s;
        s = 3'd0;
        if (HIGH_FIRST != 0) begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) s = i[2:0];
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) s = i[2:0];
            end
        end
        return s;
    endfunction

    // Handshake decode and pending/overflow next-state
    always_comb begin
        accept     = (state_q == S_PRESENT) && out_ready;
        idx_onehot = 8'b0000_0001 << out_idx_q;
        acc_mask   = accept ? idx_onehot : 8'h00;
        cand       = pending_q & ~idx_onehot;
        // A request on the bit being retired re-arms it as a fresh event
        pending_d  = (pending_q & ~acc_mask) | req;
        ovf_set    = |(req & pending_q & ~acc_mask);
        // Set has priority over clear so a same-cycle collision is not lost
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Presenter FSM: only registered pending is ever a candidate
    always_comb begin
        state_d   = state_q;
        out_idx_d = out_idx_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q != 8'h00) begin
                    state_d   = S_PRESENT;
                    out_idx_d = prio_sel(pending_q);
                end
            end
            S_PRESENT: begin
                // Without ready the presented index is frozen, no pre-emption
                if (out_ready) begin
                    if (cand != 8'h00) begin
                        out_idx_d = prio_sel(cand);
                    end else begin
                        state_d = S_IDLE;   // out_idx keeps its last value
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset discards every captured event at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            out_idx_q <= 3'd0;
            pending_q <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_idx_q <= out_idx_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_idx   = out_idx_q;
    assign out_valid = (state_q == S_PRESENT);
    assign pending   = pending_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_event_encoder_8to3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_event_encoder_8to3
//  Purpose  : Self-checking bench for event_encoder_8to3. A vector table
//             drives the HIGH_FIRST=1 instance; delivered indices are checked
//             against a scoreboard queue. Short hand sequences cover the
//             HIGH_FIRST=0 order and asynchronous reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_event_encoder_8to3;

    typedef struct {
        logic [7:0]  req;
        logic        rdy;
        logic        clr;
        int          n_push;   // number of indices this stimulus will deliver
        logic [8:0]  push;     // delivery order, lowest 3 bits first
        logic [12:0] exp;      // {valid, idx, pending, ovf} after the edge
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       out_ready;
    logic       ovf_clr;
    logic [2:0] out_idx;
    logic       out_valid;
    logic [7:0] pending;
    logic       ovf;

    logic [7:0] req_lo;
    logic       rdy_lo;
    logic       clr_lo;
    logic [2:0] idx_lo;
    logic       valid_lo;
    logic [7:0] pend_lo;
    logic       ovf_lo;

    int         n_vec;
    int         n_miss;
    logic [2:0] sb[$];
    vec_t       tbl[$];

    event_encoder_8to3 #(.HIGH_FIRST(1)) u_hi (
        .clk(clk), .rst_n(rst_n), .req(req), .out_idx(out_idx),
        .out_valid(out_valid), .out_ready(out_ready), .pending(pending),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    event_encoder_8to3 #(.HIGH_FIRST(0)) u_lo (
        .clk(clk), .rst_n(rst_n), .req(req_lo), .out_idx(idx_lo),
        .out_valid(valid_lo), .out_ready(rdy_lo), .pending(pend_lo),
        .ovf(ovf_lo), .ovf_clr(clr_lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] r, input logic rd, input logic c,
                                input int np, input logic [8:0] pv,
                                input logic v, input logic [2:0] idx,
                                input logic [7:0] pend, input logic o);
        vec_t t;
        t.req = r; t.rdy = rd; t.clr = c; t.n_push = np; t.push = pv;
        t.exp = {v, idx, pend, o};
        return t;
    endfunction

    // Drive one cycle of stimulus on the HIGH_FIRST=1 instance, score any
    // handshake mid-cycle, then compare registered outputs after the edge
    task automatic apply(input vec_t t, input string nm);
        logic [2:0] e;
        req = t.req; out_ready = t.rdy; ovf_clr = t.clr;
        for (int k = 0; k < t.n_push; k++) begin
            e = t.push[3*k +: 3];
            sb.push_back(e);
        end
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("handshake_unexpected", {29'd0, out_idx}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("handshake_idx", {29'd0, out_idx}, {29'd0, e});
            end
        end
        @(posedge clk); #1;
        check(nm, {19'd0, out_valid, out_idx, pending, ovf}, {19'd0, t.exp});
    endtask

    initial begin
        logic [2:0] lo_idx[4];
        logic       lo_val[4];
        n_vec = 0; n_miss = 0;
        rst_n = 1'b0; req = 8'h00; out_ready = 1'b0; ovf_clr = 1'b0;
        req_lo = 8'h00; rdy_lo = 1'b0; clr_lo = 1'b0;

        //           req    rdy  clr  n  push                    v  idx  pend   ovf
        // single event, valid for exactly one cycle
        tbl.push_back(mk(8'h20, 1, 0, 1, 9'd5,                 0, 3'd0, 8'h00, 0)); // pend is req of this edge
        tbl[0].exp = {1'b0, 3'd0, 8'h20, 1'b0};
        tbl.push_back(mk(8'h00, 1, 0, 0, 9'd0,                 1, 3'd5, 8'h20, 0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 9'd0,                 0, 3'd5, 8'h00, 0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 9'd0,                 0, 3'd5, 8'h00, 0));
        // simultaneous events, back-to-back 7,4,0
        tbl.push_back(mk(8'h91, 1, 0, 3, {3'd0, 3'd4, 3'd7},   0, 3'd5, 8'h91, 0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 9'd0,                 1, 3'd7, 8'h91, 0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 9'd0,                 1, 3'd4, 8'h11, 0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 9'd0,                 1, 3'd0, 8'h01, 0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 9'd0,                 0, 3'd0, 8'h00, 0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 9'd0,                 0, 3'd0, 8'h00, 0));
        // backpressure: 2 stays presented, later 7 does not pre-empt
        tbl.push_back(mk(8'h04, 0, 0, 2, {3'd0, 3'd7, 3'd2},   0, 3'd0, 8'h04, 0));
        tbl.push_back(mk(8'h00, 0, 0, 0, 9'd0,                 1, 3'd2, 8'h04, 0));
        tbl.push_back(mk(8'h00, 0, 0, 0, 9'd0,                 1, 3'd2, 8'h04, 0));
        tbl.push_back(mk(8'h80, 0, 0, 0, 9'd0,                 1, 3'd2, 8'h84, 0));
        tbl.push_back(mk(8'h00, 0, 0, 0, 9'd0,                 1, 3'd2, 8'h84, 0));
        tbl.push_back(mk(8'h00, 0, 0, 0, 9'd0,                 1, 3'd2, 8'h84, 0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 9'd0,                 1, 3'd7, 8'h80, 0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 9'd0,                 0, 3'd7, 8'h00, 0));
        // overflow: merged event, single delivery, then clear
        tbl.push_back(mk(8'h02, 0, 0, 1, 9'd1,                 0, 3'd7, 8'h02, 0));
        tbl.push_back(mk(8'h02, 0, 0, 0, 9'd0,                 1, 3'd1, 8'h02, 1));
        tbl.push_back(mk(8'h00, 1, 0, 0, 9'd0,                 0, 3'd1, 8'h00, 1));
        tbl.push_back(mk(8'h00, 0, 1, 0, 9'd0,                 0, 3'd1, 8'h00, 0));
        // overflow set beats same-cycle clear
        tbl.push_back(mk(8'h02, 0, 0, 1, 9'd1,                 0, 3'd1, 8'h02, 0));
        tbl.push_back(mk(8'h02, 0, 1, 0, 9'd0,                 1, 3'd1, 8'h02, 1));
        tbl.push_back(mk(8'h00, 1, 1, 0, 9'd0,                 0, 3'd1, 8'h00, 0));
        // re-request on accept: no overflow, index 3 delivered twice
        tbl.push_back(mk(8'h08, 0, 0, 2, {3'd0, 3'd3, 3'd3},   0, 3'd1, 8'h08, 0));
        tbl.push_back(mk(8'h00, 0, 0, 0, 9'd0,                 1, 3'd3, 8'h08, 0));
        tbl.push_back(mk(8'h08, 1, 0, 0, 9'd0,                 0, 3'd3, 8'h08, 0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 9'd0,                 1, 3'd3, 8'h08, 0));
        tbl.push_back(mk(8'h00, 1, 0, 0, 9'd0,                 0, 3'd3, 8'h00, 0));

        // reset state of both instances
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_hi", {19'd0, out_valid, out_idx, pending, ovf}, 32'd0);
        check("reset_lo", {19'd0, valid_lo, idx_lo, pend_lo, ovf_lo}, 32'd0);

        // HIGH_FIRST=0 instance: 0,4,7 then idle
        req_lo = 8'h91; rdy_lo = 1'b1;
        @(posedge clk); #1;
        check("lo_capture", {24'd0, pend_lo}, 32'h91);
        req_lo = 8'h00;
        lo_idx[0] = 3'd0; lo_idx[1] = 3'd4; lo_idx[2] = 3'd7; lo_idx[3] = 3'd7;
        lo_val[0] = 1'b1; lo_val[1] = 1'b1; lo_val[2] = 1'b1; lo_val[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("lo_seq%0d", i), {28'd0, valid_lo, idx_lo},
                  {28'd0, lo_val[i], lo_idx[i]});
        end
        rdy_lo = 1'b0;

        // vector table on the HIGH_FIRST=1 instance
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // asynchronous reset mid-operation
        apply(mk(8'hFF, 0, 0, 0, 9'd0, 0, 3'd3, 8'hFF, 0), "fill");
        apply(mk(8'hFF, 0, 0, 0, 9'd0, 1, 3'd7, 8'hFF, 1), "fill_ovf");
        req = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {22'd0, out_valid, pending, ovf}, 32'd0);
        @(posedge clk); #1;
        check("reset_held", {19'd0, out_valid, out_idx, pending, ovf}, 32'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(mk(8'h00, 0, 0, 0, 9'd0, 0, 3'd0, 8'h00, 0), $sformatf("post_reset%0d", i));
        end

        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/event_encoder_8to3.md
Name: event_encoder_8to3

Overview:
- Sequential counterpart of the team's 3-to-8 select decoder: collects eight event request lines and returns them as 3-bit indices, one at a time.
- Each captured event is held pending and delivered over a valid/ready handshake in fixed priority order. Highest index wins by default.
- Sits between event sources and a consumer that drives a 3-to-8 decoder or indexes a table.

Parameters:
- HIGH_FIRST, 1, 1 = index 7 has highest priority; 0 = index 0 has highest priority.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous assert, active-low
- req  input  8  event requests, sampled each rising edge; any level/pulse high = one event on that bit per cycle
- out_idx  output  3  encoded index of the presented event
- out_valid  output  1  out_idx holds a pending event
- out_ready  input  1  consumer accepts when out_valid && out_ready at a rising edge
- pending  output  8  registered pending-event vector (status)
- ovf  output  1  sticky overflow flag
- ovf_clr  input  1  synchronous clear of ovf

Behaviour:
- Reset (rst_n low, asynchronous): pending=8'h00, out_idx=3'd0, out_valid=0, ovf=0. FSM returns to IDLE immediately. All captured events are discarded. Reset release is sampled by clk.
- FSM states: IDLE (out_valid=0) and PRESENT (out_valid=1).
- Pending update at each edge:
  - pending_next = (pending & ~acc_mask) | req.
  - acc_mask = onehot(out_idx) when out_valid && out_ready, else 0.
  - A req bit high in the same cycle its index is accepted leaves that bit set. This counts as a new event.
- Overflow:
  - ovf sets when req[i]=1 while pending[i]=1 and bit i is not being accepted that cycle. The event is merged, not queued.
  - ovf_clr=1 clears ovf. If clear and a new overflow occur in the same cycle, set wins.
- Selection: sel = priority encode of candidate vector cand, per HIGH_FIRST. Only registered pending is used; same-cycle req is never a candidate.
- IDLE: if pending != 0, go to PRESENT and load out_idx = sel(pending). Otherwise stay.
- PRESENT, out_ready=0:
  - out_idx and out_valid are held stable.
  - A newly arriving higher-priority event does not pre-empt the presented one.
- PRESENT, out_ready=1 (accept):
  - cand = pending & ~onehot(out_idx).
  - If cand != 0: stay in PRESENT and load out_idx = sel(cand). This gives back-to-back delivery, one index per cycle.
  - Otherwise go to IDLE, with out_idx holding its last value.
- Latency:
  - req high at edge k sets pending after edge k.
  - out_valid/out_idx appear after edge k+1, i.e. 2 cycles from req to out_valid when idle.
- Throughput: one accepted index per clock with out_ready held high.
- out_idx is don't-care when out_valid=0. It is still deterministic: the last value is held.

Test Plan:
- Single event: idle, req=8'h20 for 1 cycle, out_ready=1 → out_valid=1 with out_idx=5 two cycles later, valid for exactly 1 cycle. pending returns to 8'h00 after the accept.
- Simultaneous events, HIGH_FIRST=1: req=8'h91 one cycle, out_ready=1 → out_idx sequence 7,4,0 on consecutive cycles, then out_valid=0. With HIGH_FIRST=0 the sequence is 0,4,7.
- Backpressure: req=8'h04, out_ready=0 for 5 cycles, and req=8'h80 in the 3rd cycle → out_idx stays 2 all 5 cycles. Raising out_ready then delivers 2 followed by 7.
- Overflow: req=8'h02 on two consecutive cycles while out_ready=0 → ovf=1 and a single index 1 is delivered. Pulsing ovf_clr gives ovf=0.
- Re-request on accept: index 3 presented, out_ready=1 with req=8'h08 in the same cycle → pending[3] stays 1, ovf stays 0, and index 3 is delivered again next.
- Reset mid-operation: pending=8'hFF, PRESENT; drop rst_n between clock edges → out_valid, pending and ovf go to 0 immediately, without waiting for a clock edge. After release with req=0, out_valid stays 0.
